// File: rtl/clk_activity_monitor_if.sv
// ============================================================================
// clk_activity_monitor_if
//
// Groups the measurement control and result signals of clk_activity_monitor.
// The clock and reset are kept outside the interface as plain ports.
//
// Parameters
//   NUM_CH : number of monitored channels (must match the monitor's NUM_CH)
//   CNT_W  : width of each per-channel edge count (must match the monitor)
//
// Signals
//   en           : measurement enable                  (master -> slave)
//   ch_in        : monitored clock-derived signals     (master -> slave)
//   edge_cnt     : latched rising-edge counts, channel i at [i*CNT_W +: CNT_W]
//   alive        : per-channel flag, latched count >= MIN_EDGES
//   stuck_any    : any alive bit is 0 in the latest result
//   result_valid : one-cycle pulse when a new result is latched
//   busy         : high while a measurement is running
//
// Modports
//   master : the side that drives en/ch_in and observes the results
//   slave  : the activity monitor itself
// ============================================================================
interface clk_activity_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 9
);
    logic                      en;
    logic [NUM_CH-1:0]         ch_in;
    logic [NUM_CH*CNT_W-1:0]   edge_cnt;
    logic [NUM_CH-1:0]         alive;
    logic                      stuck_any;
    logic                      result_valid;
    logic                      busy;

    modport master (
        output en,
        output ch_in,
        input  edge_cnt,
        input  alive,
        input  stuck_any,
        input  result_valid,
        input  busy
    );

    modport slave (
        input  en,
        input  ch_in,
        output edge_cnt,
        output alive,
        output stuck_any,
        output result_valid,
        output busy
    );
endinterface

// File: rtl/clk_activity_monitor.sv
// ============================================================================
// clk_activity_monitor
//
// Counts rising edges on NUM_CH clock-derived signals over a fixed window of
// WINDOW clk cycles and reports, once per window, the per-channel counts, a
// per-channel alive flag (count >= MIN_EDGES) and a stuck_any summary flag.
// Windows run back to back while en is high; dropping en mid-window discards
// the partial window and keeps the last published result.
//
// Parameters
//   NUM_CH    : number of monitored channels
//   WINDOW    : window length in clk cycles, 2..65535
//   CNT_W     : width of each per-channel edge count (saturating)
//   MIN_EDGES : minimum edges per window for a channel to be alive
//
// Ports
//   clk   : single clock, all logic on its rising edge
//   rst_n : asynchronous active-low reset, released synchronously upstream
//   bus   : clk_activity_monitor_if.slave (en, ch_in in; results out)
//
// Build option
//   CLK_ACTIVITY_MONITOR_SYNC_EN : when defined, each channel passes through a
//   2-flop synchronizer ahead of the sample register (edge latency 3 cycles
//   instead of 1). Window, latch and reset behaviour are the same either way.
// ============================================================================
module clk_activity_monitor #(
    parameter int NUM_CH    = 4,
    parameter int WINDOW    = 256,
    parameter int CNT_W     = 9,
    parameter int MIN_EDGES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    clk_activity_monitor_if.slave bus
);

    localparam int                WIN_W    = $clog2(WINDOW);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t state;
    state_t state_nx;

    // ------------------------------------------------------------------------
    // Input sampling and edge detection. These registers run in every state
    // so the first MEASURE cycle compares against a fresh previous sample.
    // ------------------------------------------------------------------------
    logic [NUM_CH-1:0] s;
    logic [NUM_CH-1:0] prev;
    logic [NUM_CH-1:0] rise;

`ifdef CLK_ACTIVITY_MONITOR_SYNC_EN
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            s     <= '0;
            prev  <= '0;
        end else begin
            sync1 <= bus.ch_in;
            sync2 <= sync1;
            s     <= sync2;
            prev  <= s;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s    <= '0;
            prev <= '0;
        end else begin
            s    <= bus.ch_in;
            prev <= s;
        end
    end
`endif

    assign rise = s & ~prev;

    // ------------------------------------------------------------------------
    // FSM: state register plus next-state / output decode.
    // ------------------------------------------------------------------------
    logic win_last;
    logic busy_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    logic [WIN_W-1:0] win;

    always_comb begin
        state_nx = state;
        busy_c   = 1'b0;
        win_last = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en) begin
                    state_nx = MEASURE;
                end
            end
            MEASURE: begin
                busy_c   = 1'b1;
                win_last = (win == WIN_LAST);
                if (!bus.en) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Per-channel accumulators. acc_inc is the accumulator value including
    // this cycle's edge, saturated, so the final window cycle is not lost and
    // alive is judged on the saturated count.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0]  acc     [NUM_CH];
    logic [CNT_W-1:0]  acc_inc [NUM_CH];
    logic [NUM_CH-1:0] alive_nx;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            acc_inc[i]  = acc[i];
            alive_nx[i] = 1'b0;
            if (rise[i] && (acc[i] != '1)) begin
                acc_inc[i] = acc[i] + 1'b1;
            end
            alive_nx[i] = (32'(acc_inc[i]) >= 32'(MIN_EDGES));
        end
    end

    // ------------------------------------------------------------------------
    // Window counter, accumulators and latched results.
    // The final window cycle latches even if en drops on that same cycle;
    // any other cycle with en low discards the partial window.
    // ------------------------------------------------------------------------
    logic [NUM_CH*CNT_W-1:0] edge_cnt_q;
    logic [NUM_CH-1:0]       alive_q;
    logic                    stuck_q;
    logic                    valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win        <= '0;
            edge_cnt_q <= '0;
            alive_q    <= '0;
            stuck_q    <= 1'b0;
            valid_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            if (state == MEASURE && win_last) begin
                win     <= '0;
                valid_q <= 1'b1;
                alive_q <= alive_nx;
                stuck_q <= ~&alive_nx;
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    edge_cnt_q[i*CNT_W +: CNT_W] <= acc_inc[i];
                    acc[i]                       <= '0;
                end
            end else if (state == MEASURE && bus.en) begin
                win <= win + 1'b1;
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    acc[i] <= acc_inc[i];
                end
            end else begin
                // IDLE, or an aborted window: hold counter and accumulators at 0.
                win <= '0;
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    acc[i] <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.edge_cnt     = edge_cnt_q;
    assign bus.alive        = alive_q;
    assign bus.stuck_any    = stuck_q;
    assign bus.result_valid = valid_q;
    assign bus.busy         = busy_c;

endmodule

// File: tb/tb_clk_activity_monitor.sv
// ============================================================================
// tb_clk_activity_monitor
//
// Two monitors share one stimulus: dut_a (CNT_W=5) and dut_b (CNT_W=3, to
// exercise saturation). The reference model records every sampled input
// vector and, at each window close, counts 0->1 transitions over the span of
// samples that the window covers, shifted by the input latency of the build.
// ============================================================================
module tb_clk_activity_monitor;

    localparam int NUM_CH    = 2;
    localparam int WINDOW    = 16;
    localparam int CNT_W     = 5;
    localparam int CNT_W_B   = 3;
    localparam int MIN_EDGES = 2;

`ifdef CLK_ACTIVITY_MONITOR_SYNC_EN
    localparam int LAT  = 3;
    localparam bit SYNC = 1'b1;
`else
    localparam int LAT  = 1;
    localparam bit SYNC = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    clk_activity_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W))   bus_a ();
    clk_activity_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W_B)) bus_b ();

    clk_activity_monitor #(
        .NUM_CH   (NUM_CH),
        .WINDOW   (WINDOW),
        .CNT_W    (CNT_W),
        .MIN_EDGES(MIN_EDGES)
    ) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_a)
    );

    clk_activity_monitor #(
        .NUM_CH   (NUM_CH),
        .WINDOW   (WINDOW),
        .CNT_W    (CNT_W_B),
        .MIN_EDGES(MIN_EDGES)
    ) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b)
    );

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    int                n_vec = 0;
    int                n_err = 0;
    int                n     = -1;          // index of the latest clock edge
    bit [NUM_CH-1:0]   hist [0:4095];       // input vector sampled at each edge
    bit                meas    = 1'b0;
    int                wstart  = 0;         // edge that processes window cycle 0
    int                m_raw [NUM_CH];
    bit [NUM_CH-1:0]   m_alive_a = '0;
    bit [NUM_CH-1:0]   m_alive_b = '0;
    bit                m_stuck_a = 1'b0;
    bit                m_stuck_b = 1'b0;
    bit                m_valid   = 1'b0;
    bit                m_busy    = 1'b0;

    function automatic int sat(input int raw, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (raw > mx) ? mx : raw;
    endfunction

    // Rising edges whose effect lands on edges first_p..last_p.
    function automatic int count_edges(input int ch, input int first_p, input int last_p);
        int cnt;
        int k;
        bit cur;
        bit prv;
        cnt = 0;
        for (int p = first_p; p <= last_p; p++) begin
            k = p - LAT;
            if (k >= 0) begin
                cur = hist[k][ch];
                prv = (k > 0) ? hist[k-1][ch] : 1'b0;
                if (cur && !prv) cnt++;
            end
        end
        return cnt;
    endfunction

    task automatic model_reset();
        meas      = 1'b0;
        m_valid   = 1'b0;
        m_busy    = 1'b0;
        m_alive_a = '0;
        m_alive_b = '0;
        m_stuck_a = 1'b0;
        m_stuck_b = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) m_raw[ch] = 0;
    endtask

    task automatic model_latch(input int last_edge);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_raw[ch]     = count_edges(ch, last_edge - WINDOW + 1, last_edge);
            m_alive_a[ch] = sat(m_raw[ch], CNT_W)   >= MIN_EDGES;
            m_alive_b[ch] = sat(m_raw[ch], CNT_W_B) >= MIN_EDGES;
        end
        m_stuck_a = (m_alive_a != '1);
        m_stuck_b = (m_alive_b != '1);
        m_valid   = 1'b1;
    endtask

    task automatic model_edge(input bit e, input bit [NUM_CH-1:0] c);
        n++;
        hist[n] = rst_n ? c : '0;
        m_valid = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (meas) begin
            if (n == wstart + WINDOW - 1) begin
                model_latch(n);
                wstart = n + 1;
                meas   = e;
            end else if (!e) begin
                meas = 1'b0;
            end
        end else if (e) begin
            meas   = 1'b1;
            wstart = n + 1;
        end
        m_busy = meas;
    endtask

    // ------------------------------------------------------------------------
    // Comparison helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/a_valid"}, 32'(bus_a.result_valid), 32'(m_valid));
        chk({tag, "/a_busy"},  32'(bus_a.busy),         32'(m_busy));
        chk({tag, "/a_alive"}, 32'(bus_a.alive),        32'(m_alive_a));
        chk({tag, "/a_stuck"}, 32'(bus_a.stuck_any),    32'(m_stuck_a));
        chk({tag, "/b_valid"}, 32'(bus_b.result_valid), 32'(m_valid));
        chk({tag, "/b_busy"},  32'(bus_b.busy),         32'(m_busy));
        chk({tag, "/b_alive"}, 32'(bus_b.alive),        32'(m_alive_b));
        chk({tag, "/b_stuck"}, 32'(bus_b.stuck_any),    32'(m_stuck_b));
        for (int ch = 0; ch < NUM_CH; ch++) begin
            chk($sformatf("%s/a_cnt%0d", tag, ch),
                32'(bus_a.edge_cnt[ch*CNT_W +: CNT_W]), 32'(sat(m_raw[ch], CNT_W)));
            chk($sformatf("%s/b_cnt%0d", tag, ch),
                32'(bus_b.edge_cnt[ch*CNT_W_B +: CNT_W_B]), 32'(sat(m_raw[ch], CNT_W_B)));
        end
    endtask

    // Drive inputs in the low phase, let one rising edge pass, check at the
    // following falling edge.
    task automatic step(input string tag, input bit e, input bit [NUM_CH-1:0] c);
        bus_a.en    = e;
        bus_b.en    = e;
        bus_a.ch_in = c;
        bus_b.ch_in = c;
        @(posedge clk);
        model_edge(e, c);
        @(negedge clk);
        check_all(tag);
    endtask

    // ------------------------------------------------------------------------
    // Directed + random sequence
    // ------------------------------------------------------------------------
    initial begin : main
        bit tog;
        int pulses;

        bus_a.en = 1'b0; bus_a.ch_in = '0;
        bus_b.en = 1'b0; bus_b.ch_in = '0;
        model_reset();
        tog = 1'b0;

        // Reset state
        #1;
        check_all("reset");
        for (int i = 0; i < 3; i++) step("reset_hold", 1'b0, '0);
        rst_n = 1'b1;

        // ch0 toggles, ch1 idle, three windows
        for (int i = 0; i < 6; i++) begin
            tog = ~tog;
            step("s1_pre", 1'b0, {1'b0, tog});
        end
        pulses = 0;
        for (int j = 0; j <= 48; j++) begin
            tog = ~tog;
            step("s1", 1'b1, {1'b0, tog});
            if (bus_a.result_valid === 1'b1) pulses++;
        end
        chk("s1_pulses",   32'(pulses), 32'd3);
        chk("s1_valid",    32'(bus_a.result_valid), 32'd1);
        chk("s1_cnt0",     32'(bus_a.edge_cnt[0 +: CNT_W]), 32'd8);
        chk("s1_cnt1",     32'(bus_a.edge_cnt[CNT_W +: CNT_W]), 32'd0);
        chk("s1_alive",    32'(bus_a.alive), 32'b01);
        chk("s1_stuck",    32'(bus_a.stuck_any), 32'd1);
        chk("s1_sat_cnt0", 32'(bus_b.edge_cnt[0 +: CNT_W_B]), 32'd7);
        chk("s1_sat_alive",32'(bus_b.alive), 32'b01);

        // Both channels toggle
        for (int j = 0; j < 32; j++) begin
            tog = ~tog;
            step("s2", 1'b1, {tog, tog});
        end
        chk("s2_valid", 32'(bus_a.result_valid), 32'd1);
        chk("s2_cnt0",  32'(bus_a.edge_cnt[0 +: CNT_W]), 32'd8);
        chk("s2_cnt1",  32'(bus_a.edge_cnt[CNT_W +: CNT_W]), 32'd8);
        chk("s2_alive", 32'(bus_a.alive), 32'b11);
        chk("s2_stuck", 32'(bus_a.stuck_any), 32'd0);

        // Abort at window cycle 9, then re-enable
        for (int j = 0; j < 9; j++) begin
            tog = ~tog;
            step("s3_run", 1'b1, {tog, tog});
        end
        tog = ~tog;
        step("s3_drop", 1'b0, {tog, tog});
        chk("s3_busy_off",  32'(bus_a.busy), 32'd0);
        chk("s3_no_valid",  32'(bus_a.result_valid), 32'd0);
        chk("s3_hold_cnt0", 32'(bus_a.edge_cnt[0 +: CNT_W]), 32'd8);
        for (int j = 0; j < 3; j++) begin
            tog = ~tog;
            step("s3_idle", 1'b0, {tog, tog});
        end
        for (int j = 0; j <= 16; j++) begin
            tog = ~tog;
            step("s3_re", 1'b1, {tog, tog});
        end
        chk("s3_re_valid", 32'(bus_a.result_valid), 32'd1);
        chk("s3_re_cnt0",  32'(bus_a.edge_cnt[0 +: CNT_W]), 32'd8);
        chk("s3_re_cnt1",  32'(bus_a.edge_cnt[CNT_W +: CNT_W]), 32'd8);

        // Asynchronous reset mid-window
        for (int j = 0; j < 5; j++) begin
            tog = ~tog;
            step("s4_run", 1'b1, {tog, tog});
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("s4_async");
        for (int j = 0; j < 4; j++) step("s4_hold", 1'b0, '0);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) step("s4_after", 1'b0, '0);

        // Single ch0 rising edge captured at window cycle 15
        for (int j = 0; j <= 32; j++) begin
            step("s5", 1'b1, (j >= 15) ? 2'b01 : 2'b00);
            if (j == 16)
                chk("s5_win1_cnt0", 32'(bus_a.edge_cnt[0 +: CNT_W]), SYNC ? 32'd0 : 32'd1);
            if (j == 32)
                chk("s5_win2_cnt0", 32'(bus_a.edge_cnt[0 +: CNT_W]), SYNC ? 32'd1 : 32'd0);
        end

        // Random activity with occasional enable drops
        for (int j = 0; j < 320; j++) begin
            step("rand", ($urandom_range(0, 24) != 0), NUM_CH'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
